// File: rtl/soc_cluster_ctrl_pkg.sv
// rtl/soc_cluster_ctrl_pkg.sv - shared types and helpers for the cluster power/boot sequencer
package soc_cluster_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_PWR_UP   = 2'd0,
        OP_PWR_DN   = 2'd1,
        OP_SET_BOOT = 2'd2,
        OP_NOP      = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_OFF        = 3'd0,
        ST_PWR_WAIT   = 3'd1,
        ST_RST_WAIT   = 3'd2,
        ST_RUN        = 3'd3,
        ST_DRAIN      = 3'd4,
        ST_RST_ASSERT = 3'd5,
        ST_CLK_OFF    = 3'd6
    } seq_state_e;

    localparam logic [63:0] BOOT_ADDR_RST_DEFAULT = 64'h1C00_8080;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One counter serves every timed state, so size it for the largest load.
    function automatic int cnt_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/soc_cluster_seq_fsm.sv
// rtl/soc_cluster_seq_fsm.sv - per-cluster power/clock/reset sequencing FSM with boot address register
module soc_cluster_seq_fsm
    import soc_cluster_ctrl_pkg::*;
#(
    parameter int          PWR_CYCLES    = 16,
    parameter int          RST_CYCLES    = 8,
    parameter int          DRAIN_TIMEOUT = 1024,
    parameter logic [63:0] BOOT_ADDR_RST = BOOT_ADDR_RST_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pwr_up_i,
    input  logic        pwr_dn_i,
    input  logic        set_boot_i,
    input  logic [63:0] addr_i,
    input  logic        busy_i,
    output logic        pow_o,
    output logic        clk_en_o,
    output logic        rstn_o,
    output logic        fetch_en_o,
    output logic [63:0] boot_addr_o,
    output logic [2:0]  state_o,
    output logic        done_o,
    output logic        drain_timeout_o
);

    localparam int CNT_W = cnt_w(PWR_CYCLES, RST_CYCLES, DRAIN_TIMEOUT);
    localparam logic [CNT_W-1:0] PWR_LOAD   = CNT_W'(PWR_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_TIMEOUT - 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_set;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= ST_OFF;
            cnt_q           <= '0;
            boot_addr_o     <= BOOT_ADDR_RST;
            done_o          <= 1'b0;
            drain_timeout_o <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_o  <= (state_q == ST_RST_WAIT && state_d == ST_RUN) ||
                       (state_q == ST_CLK_OFF  && state_d == ST_OFF);
            if (set_boot_i && state_q == ST_OFF) begin
                boot_addr_o <= addr_i;
            end
            if (pwr_up_i) begin
                drain_timeout_o <= 1'b0;
            end else if (timeout_set) begin
                drain_timeout_o <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        timeout_set = 1'b0;
        pow_o       = 1'b0;
        clk_en_o    = 1'b0;
        rstn_o      = 1'b0;
        fetch_en_o  = 1'b0;
        case (state_q)
            ST_OFF: begin
                if (pwr_up_i) begin
                    state_d = ST_PWR_WAIT;
                    cnt_d   = PWR_LOAD;
                end
            end
            ST_PWR_WAIT: begin
                pow_o = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_RST_WAIT;
                    cnt_d   = RST_LOAD;
                end
            end
            ST_RST_WAIT: begin
                pow_o    = 1'b1;
                clk_en_o = 1'b1;
                if (cnt_q == '0) state_d = ST_RUN;
            end
            ST_RUN: begin
                pow_o      = 1'b1;
                clk_en_o   = 1'b1;
                rstn_o     = 1'b1;
                fetch_en_o = 1'b1;
                if (pwr_dn_i) begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                // Fetch is already off; wait for in-flight work, but never forever.
                pow_o    = 1'b1;
                clk_en_o = 1'b1;
                rstn_o   = 1'b1;
                if (!busy_i) begin
                    state_d = ST_RST_ASSERT;
                end else if (cnt_q == '0) begin
                    state_d     = ST_RST_ASSERT;
                    timeout_set = 1'b1;
                end
            end
            ST_RST_ASSERT: begin
                pow_o    = 1'b1;
                clk_en_o = 1'b1;
                state_d  = ST_CLK_OFF;
            end
            ST_CLK_OFF: begin
                pow_o   = 1'b1;
                state_d = ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/soc_cluster_ctrl_seq.sv
// rtl/soc_cluster_ctrl_seq.sv - multi-cluster power/clock/reset/boot sequencer with command decode
module soc_cluster_ctrl_seq
    import soc_cluster_ctrl_pkg::*;
#(
    parameter int          N_CLUSTERS    = 2,
    parameter int          PWR_CYCLES    = 16,
    parameter int          RST_CYCLES    = 8,
    parameter int          DRAIN_TIMEOUT = 1024,
    parameter logic [63:0] BOOT_ADDR_RST = BOOT_ADDR_RST_DEFAULT
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic [idx_w(N_CLUSTERS)-1:0] cmd_cluster_i,
    input  logic [1:0]                   cmd_op_i,
    input  logic [63:0]                  cmd_addr_i,
    output logic                         cmd_err_o,
    input  logic [N_CLUSTERS-1:0]        cluster_busy_i,
    output logic [N_CLUSTERS-1:0]        cluster_pow_o,
    output logic [N_CLUSTERS-1:0]        cluster_clk_en_o,
    output logic [N_CLUSTERS-1:0]        cluster_rstn_o,
    output logic [N_CLUSTERS-1:0]        cluster_fetch_en_o,
    output logic [N_CLUSTERS*64-1:0]     cluster_boot_addr_o,
    output logic [N_CLUSTERS*3-1:0]      cluster_state_o,
    output logic [N_CLUSTERS-1:0]        cluster_done_o,
    output logic [N_CLUSTERS-1:0]        drain_timeout_o
);

    cmd_op_e    op;
    logic       target_valid;
    seq_state_e target_state;
    logic       fire;
    logic       err_d;

    assign op = cmd_op_e'(cmd_op_i);

    always_comb begin
        target_valid = 1'b0;
        target_state = ST_OFF;
        for (int i = 0; i < N_CLUSTERS; i++) begin
            if (int'(cmd_cluster_i) == i) begin
                target_valid = 1'b1;
                target_state = seq_state_e'(cluster_state_o[i*3 +: 3]);
            end
        end
    end

    // Out-of-range and NOP commands are always taken so the FC never stalls on them.
    assign cmd_ready_o = !target_valid || op == OP_NOP ||
                         target_state == ST_OFF || target_state == ST_RUN;
    assign fire  = cmd_valid_i && cmd_ready_o;
    assign err_d = fire && (!target_valid || (op == OP_SET_BOOT && target_state == ST_RUN));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_err_o <= 1'b0;
        end else begin
            cmd_err_o <= err_d;
        end
    end

    for (genvar i = 0; i < N_CLUSTERS; i++) begin : g_cluster
        logic sel;
        assign sel = fire && target_valid && int'(cmd_cluster_i) == i;

        soc_cluster_seq_fsm #(
            .PWR_CYCLES    (PWR_CYCLES),
            .RST_CYCLES    (RST_CYCLES),
            .DRAIN_TIMEOUT (DRAIN_TIMEOUT),
            .BOOT_ADDR_RST (BOOT_ADDR_RST)
        ) u_fsm (
            .clk_i           (clk_i),
            .rst_ni          (rst_ni),
            .pwr_up_i        (sel && op == OP_PWR_UP),
            .pwr_dn_i        (sel && op == OP_PWR_DN),
            .set_boot_i      (sel && op == OP_SET_BOOT),
            .addr_i          (cmd_addr_i),
            .busy_i          (cluster_busy_i[i]),
            .pow_o           (cluster_pow_o[i]),
            .clk_en_o        (cluster_clk_en_o[i]),
            .rstn_o          (cluster_rstn_o[i]),
            .fetch_en_o      (cluster_fetch_en_o[i]),
            .boot_addr_o     (cluster_boot_addr_o[i*64 +: 64]),
            .state_o         (cluster_state_o[i*3 +: 3]),
            .done_o          (cluster_done_o[i]),
            .drain_timeout_o (drain_timeout_o[i])
        );
    end

endmodule

// File: tb/tb_soc_cluster_ctrl_seq.sv
// tb/tb_soc_cluster_ctrl_seq.sv - directed self-checking bench for soc_cluster_ctrl_seq
module tb_soc_cluster_ctrl_seq;

    localparam int N = 3;
    localparam int P = 4;
    localparam int R = 2;
    localparam int D = 8;
    localparam logic [63:0] RST_ADDR = 64'h1C00_8080;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_cluster;
    logic [1:0]      cmd_op;
    logic [63:0]     cmd_addr;
    logic            cmd_err;
    logic [N-1:0]    busy;
    logic [N-1:0]    pow;
    logic [N-1:0]    clk_en;
    logic [N-1:0]    rstn;
    logic [N-1:0]    fetch;
    logic [N*64-1:0] boot_addr;
    logic [N*3-1:0]  state;
    logic [N-1:0]    done;
    logic [N-1:0]    timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    soc_cluster_ctrl_seq #(
        .N_CLUSTERS    (N),
        .PWR_CYCLES    (P),
        .RST_CYCLES    (R),
        .DRAIN_TIMEOUT (D)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_ni),
        .cmd_valid_i         (cmd_valid),
        .cmd_ready_o         (cmd_ready),
        .cmd_cluster_i       (cmd_cluster),
        .cmd_op_i            (cmd_op),
        .cmd_addr_i          (cmd_addr),
        .cmd_err_o           (cmd_err),
        .cluster_busy_i      (busy),
        .cluster_pow_o       (pow),
        .cluster_clk_en_o    (clk_en),
        .cluster_rstn_o      (rstn),
        .cluster_fetch_en_o  (fetch),
        .cluster_boot_addr_o (boot_addr),
        .cluster_state_o     (state),
        .cluster_done_o      (done),
        .drain_timeout_o     (timeout)
    );

    function automatic logic [3:0] outs(input int c);
        return {pow[c], clk_en[c], rstn[c], fetch[c]};
    endfunction

    function automatic logic [2:0] st(input int c);
        return state[c*3 +: 3];
    endfunction

    function automatic logic [63:0] boot(input int c);
        return boot_addr[c*64 +: 64];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cmd_valid   = 1'b0;
        cmd_op      = 2'd3;
        cmd_cluster = 2'd0;
        cmd_addr    = '0;
    endtask

    task automatic send(input int c, input logic [1:0] op, input logic [63:0] a);
        cmd_valid   = 1'b1;
        cmd_cluster = 2'(c);
        cmd_op      = op;
        cmd_addr    = a;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        busy   = '0;
        idle();
        tick();
        tick();
        for (int c = 0; c < N; c++) begin
            checks++;
            if (outs(c) !== 4'b0000) begin
                errors++;
                $display("FAIL reset_outs c%0d got %b want 0000", c, outs(c));
            end
            checks++;
            if (st(c) !== 3'd0) begin
                errors++;
                $display("FAIL reset_state c%0d got %0d want 0", c, st(c));
            end
            checks++;
            if (boot(c) !== RST_ADDR) begin
                errors++;
                $display("FAIL reset_boot c%0d got %h want %h", c, boot(c), RST_ADDR);
            end
        end
        checks++;
        if ({done, timeout, cmd_err} !== '0) begin
            errors++;
            $display("FAIL reset_flags got %b want 0", {done, timeout, cmd_err});
        end
        cmd_op = 2'd0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", cmd_ready);
        end
        idle();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_power_up(input int c);
        logic [3:0] exp;
        send(c, 2'd0, '0);
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL pwr_up_ready c%0d got %b want 1", c, cmd_ready);
        end
        tick();
        idle();
        for (int k = 1; k <= P + R + 1; k++) begin
            exp = {1'b1, k >= P + 1, k >= P + R + 1, k >= P + R + 1};
            checks++;
            if (outs(c) !== exp || done[c] !== (k == P + R + 1)) begin
                errors++;
                $display("FAIL pwr_up_seq c%0d t+%0d got %b/%b want %b/%b",
                         c, k, outs(c), done[c], exp, k == P + R + 1);
            end
            checks++;
            if (outs(2) !== 4'b0000) begin
                errors++;
                $display("FAIL pwr_up_other t+%0d got %b want 0000", k, outs(2));
            end
            tick();
        end
        checks++;
        if (st(c) !== 3'd3 || done[c] !== 1'b0) begin
            errors++;
            $display("FAIL pwr_up_run c%0d got %0d/%b want 3/0", c, st(c), done[c]);
        end
    endtask

    task automatic test_power_down();
        busy[0] = 1'b1;
        send(0, 2'd1, '0);
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL pwr_dn_ready got %b want 1", cmd_ready);
        end
        tick();
        idle();
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (st(0) !== 3'd4 || outs(0) !== 4'b1110) begin
                errors++;
                $display("FAIL drain t+%0d got %0d/%b want 4/1110", k, st(0), outs(0));
            end
            if (k < 4) tick();
        end
        busy[0] = 1'b0;
        tick();
        checks++;
        if (st(0) !== 3'd5 || outs(0) !== 4'b1100 || done[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_assert got %0d/%b/%b want 5/1100/0", st(0), outs(0), done[0]);
        end
        tick();
        checks++;
        if (st(0) !== 3'd6 || outs(0) !== 4'b1000) begin
            errors++;
            $display("FAIL clk_off got %0d/%b want 6/1000", st(0), outs(0));
        end
        tick();
        checks++;
        if (st(0) !== 3'd0 || outs(0) !== 4'b0000 || done[0] !== 1'b1 || timeout[0] !== 1'b0) begin
            errors++;
            $display("FAIL pwr_dn_off got %0d/%b/%b/%b want 0/0000/1/0",
                     st(0), outs(0), done[0], timeout[0]);
        end
        tick();
        checks++;
        if (done[0] !== 1'b0) begin
            errors++;
            $display("FAIL pwr_dn_done_pulse got %b want 0", done[0]);
        end
    endtask

    task automatic test_drain_timeout();
        test_power_up(0);
        busy[0] = 1'b1;
        send(0, 2'd1, '0);
        tick();
        idle();
        for (int k = 1; k <= D; k++) begin
            checks++;
            if (st(0) !== 3'd4 || timeout[0] !== 1'b0) begin
                errors++;
                $display("FAIL timeout_drain t+%0d got %0d/%b want 4/0", k, st(0), timeout[0]);
            end
            tick();
        end
        checks++;
        if (st(0) !== 3'd5 || timeout[0] !== 1'b1) begin
            errors++;
            $display("FAIL timeout_set got %0d/%b want 5/1", st(0), timeout[0]);
        end
        tick();
        tick();
        checks++;
        if (st(0) !== 3'd0 || done[0] !== 1'b1 || timeout[0] !== 1'b1) begin
            errors++;
            $display("FAIL timeout_off got %0d/%b/%b want 0/1/1", st(0), done[0], timeout[0]);
        end
        busy[0] = 1'b0;
        tick();
        checks++;
        if (timeout[0] !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky got %b want 1", timeout[0]);
        end
        send(0, 2'd0, '0);
        tick();
        idle();
        checks++;
        if (timeout[0] !== 1'b0 || st(0) !== 3'd1) begin
            errors++;
            $display("FAIL timeout_clear got %b/%0d want 0/1", timeout[0], st(0));
        end
        for (int k = 0; k < P + R; k++) tick();
        checks++;
        if (st(0) !== 3'd3) begin
            errors++;
            $display("FAIL timeout_rerun got %0d want 3", st(0));
        end
    endtask

    task automatic test_set_boot();
        send(1, 2'd2, 64'h1C01_0000);
        tick();
        idle();
        checks++;
        if (boot(1) !== 64'h1C01_0000 || cmd_err !== 1'b0 || boot(0) !== RST_ADDR) begin
            errors++;
            $display("FAIL set_boot_off got %h/%b/%h want 1c010000/0/%h",
                     boot(1), cmd_err, boot(0), RST_ADDR);
        end
        test_power_up(1);
        send(1, 2'd2, 64'hDEAD_BEEF);
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL set_boot_run_ready got %b want 1", cmd_ready);
        end
        tick();
        idle();
        checks++;
        if (cmd_err !== 1'b1 || boot(1) !== 64'h1C01_0000) begin
            errors++;
            $display("FAIL set_boot_run got %b/%h want 1/1c010000", cmd_err, boot(1));
        end
        tick();
        checks++;
        if (cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse got %b want 0", cmd_err);
        end
        send(3, 2'd0, '0);
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL bad_idx_ready got %b want 1", cmd_ready);
        end
        tick();
        idle();
        checks++;
        if (cmd_err !== 1'b1 || st(0) !== 3'd3 || st(1) !== 3'd3 || st(2) !== 3'd0 || pow[2] !== 1'b0) begin
            errors++;
            $display("FAIL bad_idx got %b/%0d/%0d/%0d want 1/3/3/0", cmd_err, st(0), st(1), st(2));
        end
        tick();
    endtask

    task automatic test_async_reset();
        rst_ni = 1'b0;
        #2;
        rst_ni = 1'b1;
        tick();
        send(2, 2'd2, 64'h5555);
        tick();
        idle();
        checks++;
        if (boot(2) !== 64'h5555) begin
            errors++;
            $display("FAIL boot_c2 got %h want 5555", boot(2));
        end
        send(0, 2'd0, '0);
        tick();
        cmd_valid = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_ready got %b want 0", cmd_ready);
        end
        cmd_op = 2'd3;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL nop_ready got %b want 1", cmd_ready);
        end
        send(1, 2'd0, '0);
        tick();
        idle();
        tick();
        tick();
        tick();
        checks++;
        if (st(0) !== 3'd2 || outs(0) !== 4'b1100 || st(1) !== 3'd1 || outs(1) !== 4'b1000) begin
            errors++;
            $display("FAIL concurrent got %0d/%b %0d/%b want 2/1100 1/1000",
                     st(0), outs(0), st(1), outs(1));
        end
        cmd_op = 2'd0;
        #1;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({pow, clk_en, rstn, fetch, done, timeout, cmd_err} !== '0 || state !== '0) begin
            errors++;
            $display("FAIL async_reset_outs got %b/%h want 0/0",
                     {pow, clk_en, rstn, fetch, done, timeout, cmd_err}, state);
        end
        checks++;
        if (boot(2) !== RST_ADDR || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_boot got %h/%b want %h/1", boot(2), cmd_ready, RST_ADDR);
        end
        idle();
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_power_up(0);
        checks++;
        if (outs(1) !== 4'b0000 || st(1) !== 3'd0) begin
            errors++;
            $display("FAIL c1_untouched got %b/%0d want 0000/0", outs(1), st(1));
        end
        test_power_down();
        test_drain_timeout();
        test_set_boot();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
